// File: rtl/knn_pkg.sv
// Shared definitions for the KNN distance kernel.
// DATA_W can be overridden from the command line by defining the DATA_W macro.
// Coordinates are half of the output width, so a single squared difference
// always fits in DATA_W bits.

`ifndef DATA_W
`define DATA_W 32
`endif

package knn_pkg;

    // Output width of the squared distance
    localparam int DATA_W = `DATA_W;

    // Width of each unsigned coordinate
    localparam int COORD_W = DATA_W / 2;

    // Saturation value for the squared distance
    localparam logic [DATA_W-1:0] Z_MAX = {DATA_W{1'b1}};

endpackage : knn_pkg

// File: rtl/knn_sqdiff.sv
// Squared unsigned difference of two coordinates.
// The smaller operand is subtracted from the larger, so the difference never
// needs a sign bit. Its square always fits in twice the coordinate width.

module knn_sqdiff
    import knn_pkg::*;
#(
    parameter int COORD_W = knn_pkg::COORD_W,
    parameter int DATA_W  = knn_pkg::DATA_W
) (
    input  logic [COORD_W-1:0] a,
    input  logic [COORD_W-1:0] b,
    output logic [DATA_W-1:0]  sq
);

    logic [COORD_W-1:0] absDiff;
    logic [DATA_W-1:0]  absDiffWide;

    // Absolute difference, computed larger-minus-smaller to stay unsigned
    always_comb begin
        absDiff = '0;
        if (a >= b) begin
            absDiff = a - b;
        end else begin
            absDiff = b - a;
        end
    end

    // Widen before squaring so the product keeps all of its upper bits
    always_comb begin
        absDiffWide = DATA_W'(absDiff);
        sq          = absDiffWide * absDiffWide;
    end

endmodule : knn_sqdiff

// File: rtl/knn_core.sv
// KNN distance kernel: saturating squared Euclidean distance of two 2-D points.
// The distance output is purely combinational with zero latency.
// Optional feature macro KNN_MIN_TRACK_EN adds a running-minimum tracker
// (KNN_SAMPLE, min_z, min_valid). Without it the core has no flops, and
// clk/rst remain only so the port list matches across builds.

module knn_core
    import knn_pkg::*;
#(
    parameter int DATA_W = knn_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                KNN_ENABLE,
    input  logic [DATA_W/2-1:0] x1,
    input  logic [DATA_W/2-1:0] x2,
    input  logic [DATA_W/2-1:0] y1,
    input  logic [DATA_W/2-1:0] y2,
    output logic [DATA_W-1:0]   z
`ifdef KNN_MIN_TRACK_EN
    ,
    input  logic                KNN_SAMPLE,
    output logic [DATA_W-1:0]   min_z,
    output logic                min_valid
`endif
);

    localparam int                CW   = DATA_W / 2;
    localparam logic [DATA_W-1:0] ZTOP = {DATA_W{1'b1}};

    logic [DATA_W-1:0] sqX;
    logic [DATA_W-1:0] sqY;
    logic [DATA_W:0]   sumWide;
    logic [DATA_W-1:0] sumSat;
    logic [DATA_W-1:0] zGated;

    knn_sqdiff #(
        .COORD_W (CW),
        .DATA_W  (DATA_W)
    ) uSqDiffX (
        .a  (x1),
        .b  (x2),
        .sq (sqX)
    );

    knn_sqdiff #(
        .COORD_W (CW),
        .DATA_W  (DATA_W)
    ) uSqDiffY (
        .a  (y1),
        .b  (y2),
        .sq (sqY)
    );

    // Add one bit wider than the output and clamp on carry-out instead of wrapping
    always_comb begin
        sumWide = {1'b0, sqX} + {1'b0, sqY};
        sumSat  = sumWide[DATA_W] ? ZTOP : sumWide[DATA_W-1:0];
    end

    // A disabled datapath reports a distance of zero
    always_comb begin
        zGated = '0;
        if (KNN_ENABLE) begin
            zGated = sumSat;
        end
    end

    assign z = zGated;

`ifdef KNN_MIN_TRACK_EN

    logic [DATA_W-1:0] minZ_q;
    logic [DATA_W-1:0] minZ_d;
    logic              minValid_q;
    logic              minValid_d;

    // Take a new minimum only if strictly smaller (ties keep the old value) or if nothing was sampled yet
    always_comb begin
        minZ_d     = minZ_q;
        minValid_d = minValid_q;
        if (KNN_ENABLE && KNN_SAMPLE) begin
            if (!minValid_q || (zGated < minZ_q)) begin
                minZ_d = zGated;
            end
            minValid_d = 1'b1;
        end
    end

    // Tracker registers; reset has priority over a simultaneous sample
    always_ff @(posedge clk) begin
        if (rst) begin
            minZ_q     <= ZTOP;
            minValid_q <= 1'b0;
        end else begin
            minZ_q     <= minZ_d;
            minValid_q <= minValid_d;
        end
    end

    assign min_z     = minZ_q;
    assign min_valid = minValid_q;

`else

    logic unusedClockReset;
    assign unusedClockReset = &{1'b0, clk, rst};

`endif

endmodule : knn_core

// File: tb/tb_knn_core.sv
// Self-checking bench for knn_core.
// Directed distance cases, then randomized stimulus checked against an
// arithmetic reference model. With KNN_MIN_TRACK_EN defined, the running
// minimum tracker is also exercised and checked.

module tb_knn_core;

    import knn_pkg::*;

    localparam int DW = 32;
    localparam int CW = DW / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CW-1:0] x1;
    logic [CW-1:0] x2;
    logic [CW-1:0] y1;
    logic [CW-1:0] y2;
    logic [DW-1:0] z;
`ifdef KNN_MIN_TRACK_EN
    logic          sample;
    logic [DW-1:0] minZ;
    logic          minValid;
    logic [DW-1:0] modelMin;
    logic          modelValid;
`endif

    int errorCount = 0;
    int checkCount = 0;

    // 100 MHz clock
    always #5 clk = ~clk;

    knn_core #(
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .KNN_ENABLE (en),
        .x1         (x1),
        .x2         (x2),
        .y1         (y1),
        .y2         (y2),
        .z          (z)
`ifdef KNN_MIN_TRACK_EN
        ,
        .KNN_SAMPLE (sample),
        .min_z      (minZ),
        .min_valid  (minValid)
`endif
    );

    // Reference distance from plain signed arithmetic on 64-bit integers
    function automatic logic [DW-1:0] modelZ(input logic e, input logic [CW-1:0] a1,
                                             input logic [CW-1:0] a2, input logic [CW-1:0] b1,
                                             input logic [CW-1:0] b2);
        longint dx;
        longint dy;
        longint s;
        longint top;
        dx  = longint'(a1) - longint'(a2);
        dy  = longint'(b1) - longint'(b2);
        s   = dx * dx + dy * dy;
        top = (longint'(1) << DW) - 1;
        if (!e) return '0;
        if (s > top) return {DW{1'b1}};
        return s[DW-1:0];
    endfunction

    // Compare one observed value with the expected one and log any mismatch
    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive enable and both points
    task automatic applyStimulus(input logic e, input logic [CW-1:0] a1, input logic [CW-1:0] a2,
                                 input logic [CW-1:0] b1, input logic [CW-1:0] b2);
        en = e;
        x1 = a1;
        x2 = a2;
        y1 = b1;
        y2 = b2;
    endtask

`ifdef KNN_MIN_TRACK_EN
    // Tracker reference: update on an enabled sample, strictly-smaller wins
    task automatic modelSample(input logic e, input logic s, input logic [DW-1:0] zv);
        if (e && s) begin
            if (!modelValid || zv < modelMin) modelMin = zv;
            modelValid = 1'b1;
        end
    endtask
`endif

    initial begin
        logic [DW-1:0] zExp;
        logic          eR;
        logic [CW-1:0] r1, r2, r3, r4;

        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, '0);
`ifdef KNN_MIN_TRACK_EN
        sample = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetZero", z, '0);
`ifdef KNN_MIN_TRACK_EN
        checkOutput("resetMinZ", minZ, {DW{1'b1}});
        checkOutput("resetMinValid", {31'd0, minValid}, 32'd0);
        modelMin   = {DW{1'b1}};
        modelValid = 1'b0;
        sample     = 1'b0;
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed distance cases
        applyStimulus(1'b1, 16'd1, 16'd4, 16'd8, 16'd3);
        #1 checkOutput("basic34", z, 32'd34);
        applyStimulus(1'b0, 16'd1, 16'd4, 16'd8, 16'd3);
        #1 checkOutput("disabled", z, 32'd0);
        applyStimulus(1'b1, 16'd4, 16'd1, 16'd3, 16'd8);
        #1 checkOutput("swapped34", z, 32'd34);
        applyStimulus(1'b1, 16'd7, 16'd7, 16'd9, 16'd9);
        #1 checkOutput("identical", z, 32'd0);
        applyStimulus(1'b1, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0);
        #1 checkOutput("saturate", z, 32'hFFFFFFFF);
        applyStimulus(1'b1, 16'hFFFF, 16'h0, 16'h0, 16'h0);
        #1 checkOutput("maxNoSat", z, 32'hFFFE0001);
        applyStimulus(1'b1, 16'hB505, 16'h0, 16'hB505, 16'h0);
        #1 checkOutput("nearSat", z, modelZ(1'b1, 16'hB505, 16'h0, 16'hB505, 16'h0));

`ifdef KNN_MIN_TRACK_EN
        // Directed tracker sequence: 34, 50, 9, tie, disabled sample, mid-run reset
        @(negedge clk);
        applyStimulus(1'b1, 16'd1, 16'd4, 16'd8, 16'd3);
        sample = 1'b1;
        @(posedge clk); #1;
        checkOutput("min34", minZ, 32'd34);
        checkOutput("minValid1", {31'd0, minValid}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b1, 16'd0, 16'd5, 16'd0, 16'd5);
        @(posedge clk); #1;
        checkOutput("minKeep34", minZ, 32'd34);
        @(negedge clk);
        applyStimulus(1'b1, 16'd3, 16'd0, 16'd0, 16'd0);
        @(posedge clk); #1;
        checkOutput("min9", minZ, 32'd9);
        @(negedge clk);
        applyStimulus(1'b1, 16'd0, 16'd3, 16'd0, 16'd0);
        @(posedge clk); #1;
        checkOutput("minTie", minZ, 32'd9);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        @(posedge clk); #1;
        checkOutput("minDisabledHold", minZ, 32'd9);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 16'd0, 16'd0, 16'd0, 16'd0);
        @(posedge clk); #1;
        checkOutput("midResetMinZ", minZ, {DW{1'b1}});
        checkOutput("midResetValid", {31'd0, minValid}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        sample = 1'b0;
        modelMin   = {DW{1'b1}};
        modelValid = 1'b0;
`endif

        // Randomized stimulus against the reference model
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            eR = ($urandom_range(0, 3) != 0);
            r1 = CW'($urandom);
            r2 = CW'($urandom);
            r3 = CW'($urandom);
            r4 = CW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                r1 = CW'($urandom_range(0, 20));
                r2 = CW'($urandom_range(0, 20));
                r3 = CW'($urandom_range(0, 20));
                r4 = CW'($urandom_range(0, 20));
            end
            applyStimulus(eR, r1, r2, r3, r4);
            zExp = modelZ(eR, r1, r2, r3, r4);
`ifdef KNN_MIN_TRACK_EN
            sample = ($urandom_range(0, 1) == 1);
`endif
            #1 checkOutput("randZ", z, zExp);
`ifdef KNN_MIN_TRACK_EN
            modelSample(eR, sample, zExp);
            @(posedge clk); #1;
            checkOutput("randMinZ", minZ, modelMin);
            checkOutput("randMinValid", {31'd0, minValid}, {31'd0, modelValid});
`endif
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule : tb_knn_core
